register_file: RTL

- 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Sits directly downstream of the write-register selector: its WriteReg input is the 5-bit rt/rd-selected destination.
- Provides two combinational read ports for rs/rt operand fetch and one synchronous write port.
- Adds a third read-only debug port so the board display can inspect any register.

---
 rtl/register_file_pkg.sv | 7 +
 rtl/register_file_if.sv | 27 ++
 rtl/register_file_rf_read_port.sv | 30 +++
 rtl/register_file.sv | 75 +++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared constants for the MIPS general-purpose register file.
package register_file_pkg;
    localparam int          DEF_DATA_W = 32;
    localparam int          DEF_ADDR_W = 5;
    localparam int          NUM_REGS   = 32;
    localparam logic [4:0]  ZERO_REG   = 5'd0;
endpackage

// File: rtl/register_file_if.sv
// Operand-fetch, write-back and debug-read signals of the register file.
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              RegWre;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] DbgReg;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] DbgData;

    modport master (
        output RegWre, ReadReg1, ReadReg2, WriteReg, WriteData, DbgReg,
        input  ReadData1, ReadData2, DbgData
    );

    modport slave (
        input  RegWre, ReadReg1, ReadReg2, WriteReg, WriteData, DbgReg,
        output ReadData1, ReadData2, DbgData
    );
endinterface

// File: rtl/register_file_rf_read_port.sv
// One combinational read port: $0 forced to zero, optional same-cycle write forwarding.
module rf_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
    input  logic              fwd_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] data_o
);
    logic hit;

    assign hit = fwd_en_i && (addr_i == wr_addr_i);

    always_comb begin
        data_o = regs_i[addr_i];
        if ((BYPASS != 0) && hit) begin
            data_o = wr_data_i;
        end
        // Zero check last so neither storage nor forwarding can leak into $0.
        if (addr_i == ADDR_W'(ZERO_REG)) begin
            data_o = '0;
        end
    end
endmodule

// File: rtl/register_file.sv
// 32x32 MIPS register file: two operand read ports, one debug read port, one write port.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic            CLK,
    input  logic            Reset,
    register_file_if.slave  rf
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_d [1:DEPTH-1];
    logic [DATA_W-1:0] rd_arr [DEPTH];
    logic              wr_fire;
    logic              fwd_en;

    assign wr_fire = rf.RegWre && (rf.WriteReg != ADDR_W'(ZERO_REG));
    // Reset wins over a coincident write, so forwarding must also be suppressed.
    assign fwd_en  = wr_fire && !Reset;

    always_comb begin
        regs_d = regs_q;
        if (wr_fire) begin
            regs_d[rf.WriteReg] = rf.WriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_arr[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            rd_arr[i] = regs_q[i];
        end
    end

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd1 (
        .addr_i    (rf.ReadReg1),
        .regs_i    (rd_arr),
        .fwd_en_i  (fwd_en),
        .wr_addr_i (rf.WriteReg),
        .wr_data_i (rf.WriteData),
        .data_o    (rf.ReadData1)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd2 (
        .addr_i    (rf.ReadReg2),
        .regs_i    (rd_arr),
        .fwd_en_i  (fwd_en),
        .wr_addr_i (rf.WriteReg),
        .wr_data_i (rf.WriteData),
        .data_o    (rf.ReadData2)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_dbg (
        .addr_i    (rf.DbgReg),
        .regs_i    (rd_arr),
        .fwd_en_i  (fwd_en),
        .wr_addr_i (rf.WriteReg),
        .wr_data_i (rf.WriteData),
        .data_o    (rf.DbgData)
    );
endmodule
